// File: rtl/apb_slave_regs.sv
// APB register-file slave: NUM_REGS word registers, optional access-phase wait states.
// Optional byte strobes are enabled by defining APB_PSTRB_EN.
module apb_slave_regs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic                           psel,
  input  logic                           penable,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
`endif
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           prot_err,
  output logic [1:0]                     dbg_state
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  // Handshake: a transfer completes on the edge where the FSM is in ACCESS and
  // psel, penable and pready are all 1; psel low in SETUP/ACCESS abandons it.
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic                    prot_err_q, prot_err_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [ADDR_WIDTH-1:0]   idx;
  logic                    err;
  logic                    ready_int;
  logic                    done;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign idx       = addr_q >> LSB;
  assign ready_int = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign done      = ready_int && psel && penable;

`ifdef APB_PSTRB_EN
  assign err = ((addr_q & ALIGN_MASK) != '0) || (32'(idx) >= NUM_REGS) ||
               (!write_q && (strb_q != '0));
`else
  assign err = ((addr_q & ALIGN_MASK) != '0) || (32'(idx) >= NUM_REGS);
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prot_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prot_err_q <= prot_err_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prot_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable)     state_d = SETUP;
        else if (psel && penable) prot_err_d = 1'b1;
      end
      SETUP: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          // Transfer attributes are frozen here; later bus changes are ignored.
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
`ifdef APB_PSTRB_EN
          strb_d  = pstrb;
`else
          strb_d  = '1;
`endif
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (!penable) begin
          prot_err_d = 1'b1;
          state_d    = SETUP;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // penable is high on completion, so a follow-on setup is taken from IDLE.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (idx == ADDR_WIDTH'(i)) rd_word = regs_q[i];
      if (done && write_q && !err && (idx == ADDR_WIDTH'(i))) begin
        for (int b = 0; b < NB; b++) begin
          if (strb_q[b]) regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    pready    = ready_int;
    pslverr   = ready_int && err;
    prdata    = (ready_int && !write_q && !err) ? rd_word : '0;
    prot_err  = prot_err_q;
    dbg_state = state_q;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: a default instance and one with WAIT_STATES=2, NUM_REGS=4.
module tb_apb_slave_regs;

  logic         pclk = 1'b0;
  logic         preset_n;
  logic         psel0, psel1, penable, pwrite;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic         pready0, pslverr0, prot_err0, pready1, pslverr1, prot_err1;
  logic [31:0]  prdata0, prdata1;
  logic [511:0] reg_q0;
  logic [127:0] reg_q1;
  logic [1:0]   st0, st1;
`ifdef APB_PSTRB_EN
  logic [3:0]   pstrb, wr_strb, rd_strb;
`endif

  logic [31:0] exp0 [16];
  logic [31:0] exp1 [4];
  int checks = 0;
  int fails  = 0;

  always #5 pclk = ~pclk;

  apb_slave_regs u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0), .reg_q(reg_q0),
    .prot_err(prot_err0), .dbg_state(st0));

  apb_slave_regs #(.WAIT_STATES(2), .NUM_REGS(4)) u_dut1 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel1), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready1), .prdata(prdata1), .pslverr(pslverr1), .reg_q(reg_q1),
    .prot_err(prot_err1), .dbg_state(st1));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] flat0();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = exp0[i];
    return r;
  endfunction

  function automatic logic [127:0] flat1();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = exp1[i];
    return r;
  endfunction

  // One full transfer on instance d; waits counts ACCESS cycles with pready low.
  task automatic xfer(input int d, input logic w, input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    @(posedge pclk); #1;
    if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
    penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
`ifdef APB_PSTRB_EN
    pstrb = w ? wr_strb : rd_strb;
`endif
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    waits = 0;
    while (((d == 0) ? pready0 : pready1) !== 1'b1 && waits < 20) begin
      waits++;
      @(posedge pclk); #1;
    end
    if (waits >= 20) chk("pready_timeout", 1'b0, 1'b1);
    rd  = (d == 0) ? prdata0 : prdata1;
    err = (d == 0) ? pslverr0 : pslverr1;
    @(posedge pclk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;
    preset_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_PSTRB_EN
    pstrb = 4'h0; wr_strb = 4'hF; rd_strb = 4'h0;
`endif
    for (int i = 0; i < 16; i++) exp0[i] = '0;
    for (int i = 0; i < 4; i++)  exp1[i] = '0;
    repeat (2) @(posedge pclk); #1;
    chk("rst_pready", pready0, 1'b0);
    chk("rst_pslverr", pslverr0, 1'b0);
    chk("rst_prdata", prdata0, 32'h0);
    chk("rst_prot_err", prot_err0, 1'b0);
    chk("rst_state", st0, 2'd0);
    chk("rst_regs", reg_q0, flat0());
    preset_n = 1'b1;

    xfer(0, 1'b1, 12'h012, 32'hDEADBEEF, rd, err, waits);
    chk("misal_wr_err", err, 1'b1);
    chk("misal_wr_regs", reg_q0, flat0());
    xfer(0, 1'b0, 12'h012, 32'h0, rd, err, waits);
    chk("misal_rd_err", err, 1'b1);
    chk("misal_rd_data", rd, 32'h0);

    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, rd, err, waits);
    exp0[4] = 32'hDEADBEEF;
    chk("wr10_err", err, 1'b0);
    chk("wr10_waits", waits, 0);
    chk("wr10_regs", reg_q0, flat0());
    xfer(0, 1'b0, 12'h010, 32'h0, rd, err, waits);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_err", err, 1'b0);
    chk("rd10_waits", waits, 0);

    xfer(0, 1'b1, 12'h03C, 32'h12345678, rd, err, waits);
    exp0[15] = 32'h12345678;
    xfer(0, 1'b0, 12'h03C, 32'h0, rd, err, waits);
    chk("rd3c_data", rd, 32'h12345678);
    xfer(0, 1'b1, 12'h040, 32'h00000001, rd, err, waits);
    chk("wr40_err", err, 1'b1);
    chk("wr40_regs", reg_q0, flat0());
    chk("idle_after", st0, 2'd0);

    @(posedge pclk); #1;
    psel0 = 1'b1; penable = 1'b1;
    @(posedge pclk); #1;
    chk("idle_viol_pulse", prot_err0, 1'b1);
    chk("idle_viol_state", st0, 2'd0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("idle_viol_end", prot_err0, 1'b0);
    chk("idle_viol_regs", reg_q0, flat0());

    xfer(1, 1'b0, 12'h000, 32'h0, rd, err, waits);
    chk("ws_rd_waits", waits, 2);
    chk("ws_rd_data", rd, 32'h0);
    chk("ws_rd_err", err, 1'b0);
    xfer(1, 1'b1, 12'h004, 32'h00000055, rd, err, waits);
    exp1[1] = 32'h00000055;
    chk("ws_wr4_regs", reg_q1, flat1());
    xfer(1, 1'b1, 12'h010, 32'h00000001, rd, err, waits);
    chk("oob_wr_err", err, 1'b1);
    chk("oob_wr_regs", reg_q1, flat1());

    @(posedge pclk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h0000CAFE;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("abort_acc1_state", st1, 2'd2);
    chk("abort_acc1_pready", pready1, 1'b0);
    @(posedge pclk); #1;
    psel1 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_state", st1, 2'd0);
    chk("abort_pslverr", pslverr1, 1'b0);
    chk("abort_regs", reg_q1, flat1());

    @(posedge pclk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h0BADF00D;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b0;
    @(posedge pclk); #1;
    chk("acc_viol_pulse", prot_err1, 1'b1);
    chk("acc_viol_state", st1, 2'd1);
    penable = 1'b1;
    @(posedge pclk); #1;
    paddr = 12'h00C; pwdata = 32'h0; pwrite = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    chk("frozen_pready", pready1, 1'b1);
    chk("frozen_prdata", prdata1, 32'h0);
    @(posedge pclk); #1;
    psel1 = 1'b0; penable = 1'b0;
    exp1[2] = 32'h0BADF00D;
    chk("frozen_regs", reg_q1, flat1());

`ifdef APB_PSTRB_EN
    xfer(0, 1'b1, 12'h004, 32'hFFFFFFFF, rd, err, waits);
    wr_strb = 4'b0101;
    xfer(0, 1'b1, 12'h004, 32'h00000000, rd, err, waits);
    wr_strb = 4'hF;
    exp0[1] = 32'hFF00FF00;
    chk("strb_regs", reg_q0, flat0());
    rd_strb = 4'h1;
    xfer(0, 1'b0, 12'h004, 32'h0, rd, err, waits);
    rd_strb = 4'h0;
    chk("strb_rd_err", err, 1'b1);
    chk("strb_rd_data", rd, 32'h0);
`endif

    @(posedge pclk); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h0000FFFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("mid_rst_pre_pready", pready0, 1'b1);
    preset_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) exp0[i] = '0;
    for (int i = 0; i < 4; i++)  exp1[i] = '0;
    chk("mid_rst_pready", pready0, 1'b0);
    chk("mid_rst_pslverr", pslverr0, 1'b0);
    chk("mid_rst_prdata", prdata0, 32'h0);
    chk("mid_rst_prot_err", prot_err0, 1'b0);
    chk("mid_rst_state", st0, 2'd0);
    chk("mid_rst_regs0", reg_q0, flat0());
    chk("mid_rst_regs1", reg_q1, flat1());
    psel0 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    xfer(0, 1'b1, 12'h008, 32'h00000077, rd, err, waits);
    exp0[2] = 32'h00000077;
    chk("post_rst_regs", reg_q0, flat0());
    xfer(0, 1'b0, 12'h008, 32'h0, rd, err, waits);
    chk("post_rst_rd", rd, 32'h00000077);
    chk("post_rst_waits", waits, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width; legal values 8, 16, 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, APB byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; legal range 1..256.
REQ-004 SHALL have parameter WAIT_STATES, default 0, access-phase wait cycles; legal range 0..15.
REQ-005 SHALL have port pclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port preset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port psel, input, 1, slave select.
REQ-008 SHALL have port penable, input, 1, access-phase marker.
REQ-009 SHALL have port paddr, input, ADDR_WIDTH, byte address.
REQ-010 SHALL have port pwrite, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port pwdata, input, DATA_WIDTH, write data.
REQ-012 SHALL have port pready, output, 1, transfer completion.
REQ-013 SHALL have port prdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have port pslverr, output, 1, transfer error.
REQ-015 SHALL have port reg_q, output, NUM_REGS*DATA_WIDTH, flattened register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port prot_err, output, 1, one-cycle pulse on APB protocol violation.

Function
REQ-017 FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-018 IDLE -> SETUP SHALL occur on psel=1, penable=0.
REQ-019 SETUP -> ACCESS SHALL occur on psel=1, penable=1; the wait counter SHALL load WAIT_STATES on this edge.
REQ-020 In ACCESS, pready SHALL be 1 iff the counter is 0; otherwise the counter SHALL decrement each cycle with pready=0.
REQ-021 A transfer SHALL complete on the edge where the FSM is in ACCESS and psel, penable and pready are all 1.
REQ-022 On completion the FSM SHALL move to SETUP if psel=1 and penable=0, else to IDLE.
REQ-023 Index SHALL be paddr >> log2(DATA_WIDTH/8).
REQ-024 The transfer SHALL be in error if the paddr low log2(DATA_WIDTH/8) bits are non-zero or the index is >= NUM_REGS.
REQ-025 pslverr SHALL equal the error flag while pready=1, and SHALL be 0 otherwise.
REQ-026 A write without error SHALL update the indexed register on the completion edge; an errored write SHALL modify nothing.
REQ-027 prdata SHALL show the indexed register during a read with pready=1 and no error, and SHALL be 0 otherwise.
REQ-028 psel=0 in SETUP or ACCESS SHALL abort to IDLE: no write, no error.
REQ-029 Address, data or direction changes during ACCESS SHALL be ignored; values are sampled at the SETUP -> ACCESS edge.
REQ-030 psel=1 with penable=1 while in IDLE SHALL pulse prot_err for one cycle and leave state and registers unchanged.
REQ-031 psel=1 with penable=0 in ACCESS before completion SHALL pulse prot_err and return to SETUP.
REQ-032 With WAIT_STATES=0, every transfer SHALL take exactly 2 cycles (SETUP + 1 ACCESS).

Reset
REQ-033 preset_n=0 SHALL asynchronously force state IDLE, counter 0, all registers 0, pready=0, pslverr=0, prdata=0, prot_err=0.
REQ-034 Reset mid-transfer SHALL discard the transfer with no partial write; operation SHALL resume from IDLE on the first edge after release.

Configuration
REQ-035 Macro APB_PSTRB_EN, when defined, SHALL add input pstrb, width DATA_WIDTH/8; a write SHALL update only the bytes whose strobe bit is 1.
REQ-036 With APB_PSTRB_EN defined, a read with pstrb != 0 SHALL complete with pslverr=1 and prdata=0.
REQ-037 Without APB_PSTRB_EN, there SHALL be no pstrb port and every write SHALL replace the full word.

Verification
REQ-038 Defaults, write 0x12 <- 0xDEADBEEF then read 0x12 -> error (misaligned): pslverr=1 and register unchanged; write 0x10 then read 0x10 -> prdata=0xDEADBEEF, pslverr=0, 2 cycles each.
REQ-039 WAIT_STATES=3, read 0x00 -> pready low for 3 ACCESS cycles, high on the 4th.
REQ-040 NUM_REGS=4, write 0x10 <- 0x1 -> pslverr=1 and reg_q unchanged.
REQ-041 Abort: psel dropped in the 2nd ACCESS cycle with WAIT_STATES=2 -> FSM returns to IDLE, no write; assert preset_n=0 mid-ACCESS -> all outputs 0 immediately.
REQ-042 psel=1 and penable=1 from IDLE -> prot_err=1 for 1 cycle, no transfer.
REQ-043 APB_PSTRB_EN defined, register 0x4 = 0xFFFFFFFF, write 0x4 <- 0x00000000 with pstrb=4'b0101 -> register = 0xFF00FF00.
